// File: rtl/minv_pkg.sv
// Shared encodings for the modular inverse / modular division engine.
package minv_pkg;

    // Outer controller states.
    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_HALVE_U,
        S_FIX_X1,
        S_HALVE_V,
        S_FIX_X2,
        S_CMP_UV,
        S_SUB_U,
        S_SUB_X1,
        S_ADDP_X1,
        S_SUB_V,
        S_SUB_X2,
        S_ADDP_X2,
        S_FINISH
    } state_t;

    // Operation select: plain inverse, or b times the inverse.
    typedef enum logic {
        MODE_INV = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

    // Binary inversion needs at most about two subtract rounds per operand bit.
    localparam int MAX_ITER_PER_BIT = 2;

    function automatic int max_iter_default(input int width);
        return MAX_ITER_PER_BIT * width;
    endfunction

endpackage

// File: rtl/minv_word_addsub.sv
// One word of a ripple add/subtract; carry (add) or borrow (sub) chains between words.
module minv_word_addsub #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic              sub_i,
    input  logic              cin_i,
    output logic [WORD_W-1:0] sum_o,
    output logic              cout_o
);

    logic [WORD_W:0] ext;

    // Extended-width add or subtract; the top bit is the carry out or the borrow out.
    always_comb begin
        if (sub_i) begin
            ext = {1'b0, a_i} - {1'b0, b_i} - {{WORD_W{1'b0}}, cin_i};
        end else begin
            ext = {1'b0, a_i} + {1'b0, b_i} + {{WORD_W{1'b0}}, cin_i};
        end
    end

    assign sum_o  = ext[WORD_W-1:0];
    assign cout_o = ext[WORD_W];

endmodule

// File: rtl/minv_mdiv_engine.sv
// Word-serial binary extended-GCD engine: a^-1 mod p, or b*a^-1 mod p.
module minv_mdiv_engine
    import minv_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int NWORDS   = 8,
    parameter int MAX_ITER = max_iter_default(WORD_W * NWORDS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [WORD_W*NWORDS-1:0] a_in,
    input  logic [WORD_W*NWORDS-1:0] b_in,
    input  logic [WORD_W*NWORDS-1:0] p_in,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [WORD_W*NWORDS-1:0] result
);

    localparam int WIDTH  = WORD_W * NWORDS;
    localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int ITER_W = $clog2(MAX_ITER + 2);
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NWORDS - 1);
    localparam logic [ITER_W-1:0] ITER_CAP  = ITER_W'(MAX_ITER);

    state_t state_q, state_d;
    logic [WORD_W-1:0] u_q  [NWORDS];
    logic [WORD_W-1:0] v_q  [NWORDS];
    logic [WORD_W-1:0] x1_q [NWORDS];
    logic [WORD_W-1:0] x2_q [NWORDS];
    logic [WORD_W-1:0] p_q  [NWORDS];
    logic [WIDX_W-1:0] widx_q;
    logic [ITER_W-1:0] iter_q;
    logic              cy_q, first_q, fix_shift_q, fin_err_q, fin_err_d, iter_inc;
    logic              busy_q, done_q, err_q;
    logic [WIDTH-1:0]  result_q;

    logic [WIDTH-1:0]  u_flat, v_flat, x1_flat, x2_flat, p_flat;
    logic [WIDTH-1:0]  u_shr, v_shr, x1_shr, x2_shr;
    logic [WORD_W-1:0] as_a, as_b, as_sum;
    logic              as_sub, as_cin, as_cout, last_word, pass_active;
    logic              u_one, v_one, u_zero, v_zero, first_bad;

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_flat
            assign u_flat[gi*WORD_W +: WORD_W]  = u_q[gi];
            assign v_flat[gi*WORD_W +: WORD_W]  = v_q[gi];
            assign x1_flat[gi*WORD_W +: WORD_W] = x1_q[gi];
            assign x2_flat[gi*WORD_W +: WORD_W] = x2_q[gi];
            assign p_flat[gi*WORD_W +: WORD_W]  = p_q[gi];
        end
    endgenerate

    // Halving; after a FIX pass the saved carry becomes the new MSB.
    assign u_shr  = {1'b0, u_flat[WIDTH-1:1]};
    assign v_shr  = {1'b0, v_flat[WIDTH-1:1]};
    assign x1_shr = {cy_q & fix_shift_q, x1_flat[WIDTH-1:1]};
    assign x2_shr = {cy_q & fix_shift_q, x2_flat[WIDTH-1:1]};

    assign u_one     = (u_flat == WIDTH'(1));
    assign v_one     = (v_flat == WIDTH'(1));
    assign u_zero    = (u_flat == '0);
    assign v_zero    = (v_flat == '0);
    assign first_bad = !p_flat[0] || (p_flat < WIDTH'(3)) || u_zero || (u_flat >= p_flat);
    assign last_word = (widx_q == LAST_WORD);
    assign as_cin    = (widx_q == '0) ? 1'b0 : cy_q;
    assign pass_active = (((state_q == S_FIX_X1) || (state_q == S_FIX_X2)) && !fix_shift_q)
                       || (state_q inside {S_CMP_UV, S_SUB_U, S_SUB_X1, S_ADDP_X1,
                                           S_SUB_V, S_SUB_X2, S_ADDP_X2});

    // Route the current word of the operands of the active pass into the shared adder.
    always_comb begin
        as_a   = u_q[widx_q];
        as_b   = v_q[widx_q];
        as_sub = 1'b1;
        case (state_q)
            S_FIX_X1, S_ADDP_X1: begin as_a = x1_q[widx_q]; as_b = p_q[widx_q];  as_sub = 1'b0; end
            S_FIX_X2, S_ADDP_X2: begin as_a = x2_q[widx_q]; as_b = p_q[widx_q];  as_sub = 1'b0; end
            S_SUB_X1:            begin as_a = x1_q[widx_q]; as_b = x2_q[widx_q]; end
            S_SUB_V:             begin as_a = v_q[widx_q];  as_b = u_q[widx_q];  end
            S_SUB_X2:            begin as_a = x2_q[widx_q]; as_b = x1_q[widx_q]; end
            default: ;
        endcase
    end

    minv_word_addsub #(.WORD_W(WORD_W)) u_addsub (
        .a_i    (as_a),
        .b_i    (as_b),
        .sub_i  (as_sub),
        .cin_i  (as_cin),
        .sum_o  (as_sum),
        .cout_o (as_cout)
    );

    // Next-state decisions of the outer controller.
    always_comb begin
        state_d   = state_q;
        fin_err_d = fin_err_q;
        iter_inc  = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_CHECK;
            S_CHECK: begin
                if (first_q && first_bad)    begin state_d = S_FINISH; fin_err_d = 1'b1; end
                else if (u_one || v_one)     begin state_d = S_FINISH; fin_err_d = 1'b0; end
                else if (u_zero || v_zero)   begin state_d = S_FINISH; fin_err_d = 1'b1; end
                else if (!u_q[0][0])         state_d = S_HALVE_U;
                else if (!v_q[0][0])         state_d = S_HALVE_V;
                else if (iter_q >= ITER_CAP) begin state_d = S_FINISH; fin_err_d = 1'b1; end
                else                         begin state_d = S_CMP_UV; iter_inc = 1'b1; end
            end
            S_HALVE_U: state_d = x1_q[0][0] ? S_FIX_X1 : S_CHECK;
            S_HALVE_V: state_d = x2_q[0][0] ? S_FIX_X2 : S_CHECK;
            S_FIX_X1, S_FIX_X2: if (fix_shift_q) state_d = S_CHECK;
            S_CMP_UV:  if (last_word) state_d = as_cout ? S_SUB_V : S_SUB_U;
            S_SUB_U:   if (last_word) state_d = S_SUB_X1;
            S_SUB_X1:  if (last_word) state_d = as_cout ? S_ADDP_X1 : S_CHECK;
            S_SUB_V:   if (last_word) state_d = S_SUB_X2;
            S_SUB_X2:  if (last_word) state_d = as_cout ? S_ADDP_X2 : S_CHECK;
            S_ADDP_X1, S_ADDP_X2: if (last_word) state_d = S_CHECK;
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State, working registers, counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            widx_q      <= '0;
            iter_q      <= '0;
            cy_q        <= 1'b0;
            first_q     <= 1'b0;
            fix_shift_q <= 1'b0;
            fin_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            for (int i = 0; i < NWORDS; i++) begin
                u_q[i]  <= '0;
                v_q[i]  <= '0;
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                p_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            fin_err_q <= fin_err_d;
            done_q    <= 1'b0;
            if (done_q) busy_q <= 1'b0;
            if (pass_active) begin
                cy_q   <= as_cout;
                widx_q <= last_word ? '0 : widx_q + WIDX_W'(1);
            end
            case (state_q)
                S_IDLE: if (start) begin
                    busy_q      <= 1'b1;
                    err_q       <= 1'b0;
                    result_q    <= '0;
                    first_q     <= 1'b1;
                    iter_q      <= '0;
                    widx_q      <= '0;
                    cy_q        <= 1'b0;
                    fix_shift_q <= 1'b0;
                    for (int i = 0; i < NWORDS; i++) begin
                        u_q[i]  <= a_in[i*WORD_W +: WORD_W];
                        v_q[i]  <= p_in[i*WORD_W +: WORD_W];
                        p_q[i]  <= p_in[i*WORD_W +: WORD_W];
                        x2_q[i] <= '0;
                        if (mode_t'(mode) == MODE_DIV) x1_q[i] <= b_in[i*WORD_W +: WORD_W];
                        else                           x1_q[i] <= (i == 0) ? WORD_W'(1) : '0;
                    end
                end
                S_CHECK: begin
                    first_q <= 1'b0;
                    if (iter_inc) iter_q <= iter_q + ITER_W'(1);
                end
                S_HALVE_U: for (int i = 0; i < NWORDS; i++) begin
                    u_q[i] <= u_shr[i*WORD_W +: WORD_W];
                    if (!x1_q[0][0]) x1_q[i] <= x1_shr[i*WORD_W +: WORD_W];
                end
                S_HALVE_V: for (int i = 0; i < NWORDS; i++) begin
                    v_q[i] <= v_shr[i*WORD_W +: WORD_W];
                    if (!x2_q[0][0]) x2_q[i] <= x2_shr[i*WORD_W +: WORD_W];
                end
                S_FIX_X1: begin
                    if (fix_shift_q) begin
                        for (int i = 0; i < NWORDS; i++) x1_q[i] <= x1_shr[i*WORD_W +: WORD_W];
                        fix_shift_q <= 1'b0;
                    end else begin
                        x1_q[widx_q] <= as_sum;
                        if (last_word) fix_shift_q <= 1'b1;
                    end
                end
                S_FIX_X2: begin
                    if (fix_shift_q) begin
                        for (int i = 0; i < NWORDS; i++) x2_q[i] <= x2_shr[i*WORD_W +: WORD_W];
                        fix_shift_q <= 1'b0;
                    end else begin
                        x2_q[widx_q] <= as_sum;
                        if (last_word) fix_shift_q <= 1'b1;
                    end
                end
                S_SUB_U:              u_q[widx_q]  <= as_sum;
                S_SUB_V:              v_q[widx_q]  <= as_sum;
                S_SUB_X1, S_ADDP_X1:  x1_q[widx_q] <= as_sum;
                S_SUB_X2, S_ADDP_X2:  x2_q[widx_q] <= as_sum;
                S_FINISH: begin
                    done_q   <= 1'b1;
                    err_q    <= fin_err_q;
                    result_q <= fin_err_q ? '0 : (u_one ? x1_flat : x2_flat);
                end
                default: ;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule

// File: tb/tb_minv_mdiv_engine.sv
// Self-checking bench for minv_mdiv_engine at WORD_W=8, NWORDS=2.
module tb_minv_mdiv_engine;
    import minv_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         mode;
    logic [W-1:0] a_in, b_in, p_in;
    logic         busy, done, err;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    minv_mdiv_engine #(.WORD_W(8), .NWORDS(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a_in   (a_in),
        .b_in   (b_in),
        .p_in   (p_in),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          m;
        int unsigned a, b, p;
        bit          exp_err;
        int unsigned exp_res;
        int          exp_lat;   // -1 = latency not checked
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Reference: extended Euclid over plain integers.
    function automatic void ref_op(input bit m, input longint a, input longint b, input longint p,
                                   output bit e, output longint r);
        longint t, nt, rr, nr, q, tmp;
        e = 1'b0;
        r = 0;
        if ((p % 2) == 0 || p < 3 || a == 0 || a >= p) begin
            e = 1'b1;
            return;
        end
        t = 0; nt = 1; rr = p; nr = a;
        while (nr != 0) begin
            q   = rr / nr;
            tmp = t - q * nt;  t  = nt; nt = tmp;
            tmp = rr - q * nr; rr = nr; nr = tmp;
        end
        if (rr != 1) begin
            e = 1'b1;
            return;
        end
        if (t < 0) t = t + p;
        r = m ? (b * t) % p : t;
    endfunction

    // One operation; optionally pokes a spurious start while the engine is busy.
    task automatic run_op(input bit m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] p, input bit poke,
                          output logic [W-1:0] r, output logic e, output int lat,
                          output bit tmo, output logic busy1);
        @(negedge clk);
        mode = m; a_in = a; b_in = b; p_in = p; start = 1'b1;
        tmo = 1'b1; lat = 0; busy1 = 1'b0; r = '0; e = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                busy1 = busy;
            end
            if (poke && k == 2) begin
                start = 1'b1;
                a_in = W'($urandom); b_in = W'($urandom); p_in = W'($urandom); mode = ~m;
            end
            if (k == 3) start = 1'b0;
            if (done) begin
                r = result; e = err; lat = k; tmo = 1'b0;
                break;
            end
        end
        start = 1'b0;
    endtask

    vec_t        vecs[$];
    logic [W-1:0] r;
    logic        e, b1;
    int          lat;
    bit          tmo, me;
    longint      mr;
    int unsigned primes[7] = '{65521, 32749, 7919, 251, 257, 23, 3};

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; a_in = '0; b_in = '0; p_in = '0;
        #1 rst = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_err", 32'(err), 0);
        check("reset_result", 32'(result), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        vecs.push_back('{0, 3, 0, 23, 0, 8, -1});
        vecs.push_back('{1, 3, 5, 23, 0, 17, -1});
        vecs.push_back('{0, 0, 0, 23, 1, 0, 3});
        vecs.push_back('{0, 3, 0, 22, 1, 0, 3});
        vecs.push_back('{1, 1, 7, 23, 0, 7, 3});
        vecs.push_back('{0, 1, 0, 23, 0, 1, 3});
        vecs.push_back('{0, 23, 0, 23, 1, 0, 3});
        vecs.push_back('{0, 1, 0, 1, 1, 0, 3});
        vecs.push_back('{0, 22, 0, 23, 0, 22, -1});
        vecs.push_back('{0, 6, 0, 9, 1, 0, -1});
        vecs.push_back('{1, 2, 1, 65521, 0, 32761, -1});
        vecs.push_back('{1, 17, 4, 23, 0, 7, -1});

        foreach (vecs[i]) begin
            run_op(vecs[i].m, W'(vecs[i].a), W'(vecs[i].b), W'(vecs[i].p), 1'b0, r, e, lat, tmo, b1);
            $display("vec %0d: mode=%0d a=%0d b=%0d p=%0d -> err=%0d result=%0d lat=%0d",
                     i, vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].p, e, r, lat);
            check("vec_timeout", 32'(tmo), 0);
            check("vec_busy", 32'(b1), 1);
            check("vec_err", 32'(e), 32'(vecs[i].exp_err));
            check("vec_result", 32'(r), vecs[i].exp_res);
            if (vecs[i].exp_lat >= 0) check("vec_latency", 32'(lat), 32'(vecs[i].exp_lat));
        end

        for (int n = 0; n < 150; n++) begin
            int unsigned p, a, b;
            bit m;
            if ($urandom_range(0, 1) == 1) p = primes[$urandom_range(0, 6)];
            else                           p = $urandom_range(3, 65535) | 1;
            a = $urandom_range(1, p - 1);
            b = $urandom_range(0, p - 1);
            m = 1'($urandom_range(0, 1));
            ref_op(m, longint'(a), longint'(b), longint'(p), me, mr);
            run_op(m, W'(a), W'(b), W'(p), 1'($urandom_range(0, 1)), r, e, lat, tmo, b1);
            $display("rnd %0d: mode=%0d a=%0d b=%0d p=%0d -> err=%0d result=%0d lat=%0d",
                     n, m, a, b, p, e, r, lat);
            check("rnd_timeout", 32'(tmo), 0);
            check("rnd_err", 32'(e), 32'(me));
            check("rnd_result", 32'(r), 32'(mr));
        end

        // Reset in the middle of an x1 subtract pass.
        @(negedge clk);
        mode = 1'b0; a_in = 16'd17; b_in = '0; p_in = 16'd23; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tmo = 1'b1;
        for (int k = 0; k < 500; k++) begin
            if (dut.state_q == S_SUB_X1) begin
                tmo = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("rst_reach_sub_x1", 32'(tmo), 0);
        check("rst_busy_before", 32'(busy), 1);
        #2 rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_result", 32'(result), 0);
        @(negedge clk);
        check("rst_hold_done", 32'(done), 0);
        rst = 1'b1;
        b1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) b1 = 1'b1;
        end
        check("rst_no_done", 32'(b1), 0);
        run_op(1'b0, 16'd17, 16'd0, 16'd23, 1'b0, r, e, lat, tmo, b1);
        $display("post-reset: mode=0 a=17 p=23 -> err=%0d result=%0d lat=%0d", e, r, lat);
        check("post_rst_timeout", 32'(tmo), 0);
        check("post_rst_err", 32'(e), 0);
        check("post_rst_result", 32'(r), 19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
